// File: rtl/player_motion_if.sv
// Map lookup channel between player_motion and the parent's map_rom arbiter.
// The requester holds col/row stable while map_req is high; valid answers the current request.
interface player_motion_if #(
  parameter int MAP_BITS = 4
);
  logic                map_req;
  logic [MAP_BITS-1:0] map_col;
  logic [MAP_BITS-1:0] map_row;
  logic                map_valid;
  logic [1:0]          map_val;

  modport master (
    output map_req, map_col, map_row,
    input  map_valid, map_val
  );

  modport slave (
    input  map_req, map_col, map_row,
    output map_valid, map_val
  );
endinterface

// File: rtl/player_motion.sv
// Per-frame player pose engine: world-axis moves with diagonal normalisation, shift rotation,
// and per-axis map-cell collision with wall slide. Pose outputs only change on COMMIT.
//
// state  | meaning
// IDLE   | waiting for frame tick; buttons sampled on tick
// CALC   | form candidate position, flag out-of-bounds axes as blocked
// CHK_X  | map lookup for candidate X cell on current row
// CHK_Y  | map lookup for candidate Y cell on (possibly slid) column
// COMMIT | apply unblocked axes and rotation, pulse done
module player_motion #(
  parameter int INT_BITS  = 6,
  parameter int FRAC_BITS = 10,
  parameter int MAP_BITS  = 4,
  parameter int MOVE_STEP = 5,
  parameter int DIAG_STEP = 4,
  parameter int ROT_SHIFT = 6,
  parameter int START_X   = 1280,
  parameter int START_Y   = 13824,
  parameter int FACE_X    = 0,
  parameter int FACE_Y    = -1024,
  parameter int VPL_X     = 512,
  parameter int VPL_Y     = 0,
  localparam int W        = INT_BITS + FRAC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_i,
  input  logic                move_l_i,
  input  logic                move_r_i,
  input  logic                move_f_i,
  input  logic                move_b_i,
  input  logic                rot_l_i,
  input  logic                rot_r_i,
  player_motion_if.master     map_if,
  output logic signed [W-1:0] player_x_o,
  output logic signed [W-1:0] player_y_o,
  output logic signed [W-1:0] facing_x_o,
  output logic signed [W-1:0] facing_y_o,
  output logic signed [W-1:0] vplane_x_o,
  output logic signed [W-1:0] vplane_y_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          missed_ticks_o
);

  typedef enum logic [2:0] {IDLE, CALC, CHK_X, CHK_Y, COMMIT} state_t;

  localparam int CELL_LO = FRAC_BITS;
  localparam int CELL_HI = FRAC_BITS + MAP_BITS - 1;

  localparam logic signed [W-1:0] MOVE_W = W'(MOVE_STEP);
  localparam logic signed [W-1:0] DIAG_W = W'(DIAG_STEP);
  localparam logic signed [W-1:0] RST_PX = W'(START_X);
  localparam logic signed [W-1:0] RST_PY = W'(START_Y);
  localparam logic signed [W-1:0] RST_FX = W'(FACE_X);
  localparam logic signed [W-1:0] RST_FY = W'(FACE_Y);
  localparam logic signed [W-1:0] RST_VX = W'(VPL_X);
  localparam logic signed [W-1:0] RST_VY = W'(VPL_Y);

  state_t state_q, state_d;

  logic x_mv_q, x_mv_d, x_neg_q, x_neg_d;
  logic y_mv_q, y_mv_d, y_neg_q, y_neg_d;
  logic rot_mv_q, rot_mv_d, rot_left_q, rot_left_d;
  logic blk_x_q, blk_x_d, blk_y_q, blk_y_d;

  logic signed [W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic signed [W-1:0] px_q, px_d, py_q, py_d;
  logic signed [W-1:0] fx_q, fx_d, fy_q, fy_d;
  logic signed [W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [7:0]          missed_q, missed_d;

  logic signed [W-1:0] step;
  logic signed [W-1:0] cand_x_c, cand_y_c;
  logic                oob_x, oob_y;
  logic signed [W-1:0] fx_rot, fy_rot, vx_rot, vy_rot;

  always_comb begin
    step     = (x_mv_q && y_mv_q) ? DIAG_W : MOVE_W;
    cand_x_c = px_q;
    cand_y_c = py_q;
    if (x_mv_q) cand_x_c = x_neg_q ? (px_q - step) : (px_q + step);
    if (y_mv_q) cand_y_c = y_neg_q ? (py_q - step) : (py_q + step);
  end

  // Any set bit above the cell field means negative or past the last cell.
  assign oob_x = |cand_x_c[W-1:CELL_HI+1];
  assign oob_y = |cand_y_c[W-1:CELL_HI+1];

  always_comb begin
    if (rot_left_q) begin
      fx_rot = fx_q + (fy_q >>> ROT_SHIFT);
      fy_rot = fy_q - (fx_q >>> ROT_SHIFT);
      vx_rot = vx_q + (vy_q >>> ROT_SHIFT);
      vy_rot = vy_q - (vx_q >>> ROT_SHIFT);
    end else begin
      fx_rot = fx_q - (fy_q >>> ROT_SHIFT);
      fy_rot = fy_q + (fx_q >>> ROT_SHIFT);
      vx_rot = vx_q - (vy_q >>> ROT_SHIFT);
      vy_rot = vy_q + (vx_q >>> ROT_SHIFT);
    end
  end

  always_comb begin
    state_d    = state_q;
    x_mv_d     = x_mv_q;
    x_neg_d    = x_neg_q;
    y_mv_d     = y_mv_q;
    y_neg_d    = y_neg_q;
    rot_mv_d   = rot_mv_q;
    rot_left_d = rot_left_q;
    blk_x_d    = blk_x_q;
    blk_y_d    = blk_y_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    px_d       = px_q;
    py_d       = py_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    vx_d       = vx_q;
    vy_d       = vy_q;

    case (state_q)
      IDLE: begin
        if (tick_i) begin
          x_mv_d     = move_l_i | move_r_i;
          x_neg_d    = move_l_i;
          y_mv_d     = move_f_i | move_b_i;
          y_neg_d    = move_f_i;
          rot_mv_d   = rot_l_i | rot_r_i;
          rot_left_d = rot_l_i;
          blk_x_d    = 1'b0;
          blk_y_d    = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        cand_x_d = cand_x_c;
        cand_y_d = cand_y_c;
        blk_x_d  = x_mv_q & oob_x;
        blk_y_d  = y_mv_q & oob_y;
        if (x_mv_q && !oob_x)      state_d = CHK_X;
        else if (y_mv_q && !oob_y) state_d = CHK_Y;
        else                       state_d = COMMIT;
      end
      CHK_X: begin
        if (map_if.map_valid) begin
          blk_x_d = |map_if.map_val;
          state_d = (y_mv_q && !blk_y_q) ? CHK_Y : COMMIT;
        end
      end
      CHK_Y: begin
        if (map_if.map_valid) begin
          blk_y_d = |map_if.map_val;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (x_mv_q && !blk_x_q) px_d = cand_x_q;
        if (y_mv_q && !blk_y_q) py_d = cand_y_q;
        if (rot_mv_q) begin
          fx_d = fx_rot;
          fy_d = fy_rot;
          vx_d = vx_rot;
          vy_d = vy_rot;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // CHK_Y probes the column the player will actually occupy, so a blocked X slides along Y.
  always_comb begin
    map_if.map_req = 1'b0;
    map_if.map_col = '0;
    map_if.map_row = '0;
    case (state_q)
      CHK_X: begin
        map_if.map_req = 1'b1;
        map_if.map_col = cand_x_q[CELL_HI:CELL_LO];
        map_if.map_row = py_q[CELL_HI:CELL_LO];
      end
      CHK_Y: begin
        map_if.map_req = 1'b1;
        map_if.map_col = blk_x_q ? px_q[CELL_HI:CELL_LO] : cand_x_q[CELL_HI:CELL_LO];
        map_if.map_row = cand_y_q[CELL_HI:CELL_LO];
      end
      default: ;
    endcase
  end

  always_comb begin
    missed_d = missed_q;
    if (tick_i && (state_q != IDLE) && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_mv_q     <= 1'b0;
      x_neg_q    <= 1'b0;
      y_mv_q     <= 1'b0;
      y_neg_q    <= 1'b0;
      rot_mv_q   <= 1'b0;
      rot_left_q <= 1'b0;
      blk_x_q    <= 1'b0;
      blk_y_q    <= 1'b0;
      cand_x_q   <= RST_PX;
      cand_y_q   <= RST_PY;
      px_q       <= RST_PX;
      py_q       <= RST_PY;
      fx_q       <= RST_FX;
      fy_q       <= RST_FY;
      vx_q       <= RST_VX;
      vy_q       <= RST_VY;
      missed_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      x_mv_q     <= x_mv_d;
      x_neg_q    <= x_neg_d;
      y_mv_q     <= y_mv_d;
      y_neg_q    <= y_neg_d;
      rot_mv_q   <= rot_mv_d;
      rot_left_q <= rot_left_d;
      blk_x_q    <= blk_x_d;
      blk_y_q    <= blk_y_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      missed_q   <= missed_d;
    end
  end

  assign player_x_o     = px_q;
  assign player_y_o     = py_q;
  assign facing_x_o     = fx_q;
  assign facing_y_o     = fy_q;
  assign vplane_x_o     = vx_q;
  assign vplane_y_o     = vy_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == COMMIT);
  assign missed_ticks_o = missed_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: table of single updates from reset, plus hand sequences for
// wall slide, rotation round trip, stalled lookup with missed ticks / mid-update reset, and map edge.
module tb_player_motion;
  localparam int W = 16;

  typedef struct packed {
    logic signed [W-1:0] px, py, fx, fy, vx, vy;
  } res_t;

  // btn = {move_l, move_r, move_f, move_b, rot_l, rot_r}
  typedef struct {
    logic [5:0] btn;
    bit         wall;
    int         n_lk;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic mv_l = 1'b0, mv_r = 1'b0, mv_f = 1'b0, mv_b = 1'b0, rt_l = 1'b0, rt_r = 1'b0;
  logic signed [W-1:0] px, py, fx, fy, vx, vy;
  logic       busy, done;
  logic [7:0] missed;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_lk[$];
  res_t       exp_res[$];
  bit         stall = 1'b0;
  bit         wall_all = 1'b0;
  bit         wall_en = 1'b0;
  logic [3:0] wall_col = 4'd0, wall_row = 4'd0;

  player_motion_if #(.MAP_BITS(4)) mbus ();

  player_motion dut (
    .clk(clk), .reset(reset), .tick_i(tick),
    .move_l_i(mv_l), .move_r_i(mv_r), .move_f_i(mv_f), .move_b_i(mv_b),
    .rot_l_i(rt_l), .rot_r_i(rt_r),
    .map_if(mbus),
    .player_x_o(px), .player_y_o(py), .facing_x_o(fx), .facing_y_o(fy),
    .vplane_x_o(vx), .vplane_y_o(vy),
    .busy_o(busy), .done_o(done), .missed_ticks_o(missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t mk_res(input int a, input int b, input int c, input int d, input int e, input int f);
    res_t r;
    r.px = W'(a); r.py = W'(b); r.fx = W'(c);
    r.fy = W'(d); r.vx = W'(e); r.vy = W'(f);
    return r;
  endfunction

  function automatic bit wall_at(input logic [3:0] c, input logic [3:0] r);
    return wall_all || (wall_en && c == wall_col && r == wall_row);
  endfunction

  // Map responder: answers every request with a 1-cycle valid and scores the address.
  initial begin : responder
    logic [7:0] e;
    mbus.map_valid = 1'b0;
    mbus.map_val   = 2'd0;
    forever begin
      @(negedge clk);
      mbus.map_valid = 1'b0;
      mbus.map_val   = 2'd0;
      if (mbus.map_req === 1'b1 && !stall) begin
        checks++;
        if (exp_lk.size() == 0) begin
          errors++;
          $display("FAIL lookup: unexpected request col %0d row %0d", mbus.map_col, mbus.map_row);
        end else begin
          e = exp_lk.pop_front();
          if ({mbus.map_col, mbus.map_row} !== e) begin
            errors++;
            $display("FAIL lookup addr: got col %0d row %0d, expected col %0d row %0d",
                     mbus.map_col, mbus.map_row, e[7:4], e[3:0]);
          end
        end
        mbus.map_val   = wall_at(mbus.map_col, mbus.map_row) ? 2'd2 : 2'd0;
        mbus.map_valid = 1'b1;
      end
    end
  end

  // Result monitor: pose is sampled on the cycle after done, when the commit has landed.
  initial begin : monitor
    bit   pend;
    res_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result: done with no expected result queued");
        end else begin
          e = exp_res.pop_front();
          chk("player_x", px, e.px);
          chk("player_y", py, e.py);
          chk("facing_x", fx, e.fx);
          chk("facing_y", fy, e.fy);
          chk("vplane_x", vx, e.vx);
          chk("vplane_y", vy, e.vy);
        end
      end
      pend = (done === 1'b1);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    {mv_l, mv_r, mv_f, mv_b, rt_l, rt_r} = 6'b0;
    exp_lk.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_update(input logic [5:0] b, input res_t e, input int n_lk,
                           input logic [7:0] lk0, input logic [7:0] lk1, output int lat);
    @(negedge clk);
    {mv_l, mv_r, mv_f, mv_b, rt_l, rt_r} = b;
    if (n_lk > 0) exp_lk.push_back(lk0);
    if (n_lk > 1) exp_lk.push_back(lk1);
    exp_res.push_back(e);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat  = 1;
    while (done !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done timeout: no done within %0d cycles", lat);
    end
    repeat (2) @(negedge clk);
    {mv_l, mv_r, mv_f, mv_b, rt_l, rt_r} = 6'b0;
  endtask

  initial begin : main
    vec_t       vt [13];
    int         lat;
    int         unstable;
    int         n;
    logic [3:0] col0, row0;
    logic [15:0] cy;

    vt[0]  = '{6'b000000, 1'b0, 0, mk_res(1280, 13824,   0, -1024, 512,  0)};
    vt[1]  = '{6'b010000, 1'b0, 1, mk_res(1285, 13824,   0, -1024, 512,  0)};
    vt[2]  = '{6'b011000, 1'b0, 2, mk_res(1284, 13820,   0, -1024, 512,  0)};
    vt[3]  = '{6'b110000, 1'b0, 1, mk_res(1275, 13824,   0, -1024, 512,  0)};
    vt[4]  = '{6'b001000, 1'b0, 1, mk_res(1280, 13819,   0, -1024, 512,  0)};
    vt[5]  = '{6'b001100, 1'b0, 1, mk_res(1280, 13819,   0, -1024, 512,  0)};
    vt[6]  = '{6'b100100, 1'b0, 2, mk_res(1276, 13828,   0, -1024, 512,  0)};
    vt[7]  = '{6'b000001, 1'b0, 0, mk_res(1280, 13824,  16, -1024, 512,  8)};
    vt[8]  = '{6'b000010, 1'b0, 0, mk_res(1280, 13824, -16, -1024, 512, -8)};
    vt[9]  = '{6'b000011, 1'b0, 0, mk_res(1280, 13824, -16, -1024, 512, -8)};
    vt[10] = '{6'b010000, 1'b1, 1, mk_res(1280, 13824,   0, -1024, 512,  0)};
    vt[11] = '{6'b011000, 1'b1, 2, mk_res(1280, 13824,   0, -1024, 512,  0)};
    vt[12] = '{6'b010001, 1'b0, 1, mk_res(1285, 13824,  16, -1024, 512,  8)};

    apply_reset();
    @(negedge clk);
    chk("reset player_x", px, 1280);
    chk("reset player_y", py, 13824);
    chk("reset facing_y", fy, -1024);
    chk("reset vplane_x", vx, 512);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset map_req", mbus.map_req, 0);
    chk("reset missed", missed, 0);

    // Single updates from reset; every lookup near the start cell is col 1, row 13.
    for (int i = 0; i < 13; i++) begin
      wall_all = vt[i].wall;
      apply_reset();
      do_update(vt[i].btn, vt[i].exp, vt[i].n_lk, 8'h1D, 8'h1D, lat);
      chk($sformatf("vec%0d latency", i), lat, 2 + vt[i].n_lk);
      chk($sformatf("vec%0d lookups left", i), exp_lk.size(), 0);
    end
    wall_all = 1'b0;

    // Rotation round trip returns exactly to the reset vectors.
    apply_reset();
    do_update(6'b000001, mk_res(1280, 13824, 16, -1024, 512, 8), 0, 8'h00, 8'h00, lat);
    do_update(6'b000010, mk_res(1280, 13824, 0, -1024, 512, 0), 0, 8'h00, 8'h00, lat);
    chk("rot trip latency", lat, 2);

    // Walk to x=2047 next to a wall at (2,13), then move R+B: X blocked, Y slides.
    apply_reset();
    wall_en  = 1'b1;
    wall_col = 4'd2;
    wall_row = 4'd13;
    for (int k = 0; k < 147; k++)
      do_update(6'b010000, mk_res(1280 + 5 * (k + 1), 13824, 0, -1024, 512, 0), 1, 8'h1D, 8'h00, lat);
    for (int j = 0; j < 4; j++)
      do_update(6'b011000, mk_res(2015 + 4 * (j + 1), 13824 - 4 * (j + 1), 0, -1024, 512, 0),
                2, 8'h1D, 8'h1D, lat);
    for (int j = 0; j < 4; j++)
      do_update(6'b010100, mk_res(2031 + 4 * (j + 1), 13808 + 4 * (j + 1), 0, -1024, 512, 0),
                2, 8'h1D, 8'h1D, lat);
    chk("approach x", px, 2047);
    do_update(6'b010100, mk_res(2047, 13828, 0, -1024, 512, 0), 2, 8'h2D, 8'h1D, lat);
    chk("slide latency", lat, 4);
    chk("slide lookups left", exp_lk.size(), 0);

    // Stalled lookup: extra ticks counted, address held; then reset mid-CHK_X.
    do_update(6'b000001, mk_res(2047, 13828, 16, -1024, 512, 8), 0, 8'h00, 8'h00, lat);
    stall = 1'b1;
    @(negedge clk);
    mv_r = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    mv_r = 1'b0;
    n = 0;
    while (mbus.map_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall map_req", mbus.map_req, 1);
    col0 = mbus.map_col;
    row0 = mbus.map_row;
    chk("stall col", col0, 2);
    chk("stall row", row0, 13);
    unstable = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      tick = (c == 50 || c == 120 || c == 200);
      if (mbus.map_col !== col0 || mbus.map_row !== row0 || mbus.map_req !== 1'b1) unstable++;
    end
    tick = 1'b0;
    chk("stall addr unstable cycles", unstable, 0);
    chk("stall missed", missed, 3);
    chk("stall busy", busy, 1);
    chk("stall pose untouched", px, 2047);
    #2 reset = 1'b0;
    #1;
    chk("abort map_req", mbus.map_req, 0);
    chk("abort busy", busy, 0);
    chk("abort missed", missed, 0);
    chk("abort player_x", px, 1280);
    chk("abort player_y", py, 13824);
    chk("abort facing_x", fx, 0);
    chk("abort vplane_y", vy, 0);
    stall   = 1'b0;
    wall_en = 1'b0;

    // Walk backward to the bottom map edge; the step onto 16384 is out of bounds.
    apply_reset();
    for (int k = 0; k < 511; k++) begin
      cy = 16'(13824 + 5 * (k + 1));
      do_update(6'b000100, mk_res(1280, 13824 + 5 * (k + 1), 0, -1024, 512, 0),
                1, {4'd1, cy[13:10]}, 8'h00, lat);
    end
    chk("edge approach y", py, 16379);
    do_update(6'b000100, mk_res(1280, 16379, 0, -1024, 512, 0), 0, 8'h00, 8'h00, lat);
    chk("edge oob latency", lat, 2);
    chk("edge lookups left", exp_lk.size(), 0);
    chk("edge results left", exp_res.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
